iter_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_comb.sv | 44 ++++
 rtl/iter_alu.sv | 110 +++++++++++
 tb/tb_iter_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage execution unit and the ALU control decoder.
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  // Operation code produced by the ALU control decoder
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_BEQ  = 4'b1010,
    OP_BNE  = 4'b1011,
    OP_BLT  = 4'b1100,
    OP_BGE  = 4'b1101,
    OP_UND0 = 4'b1110,
    OP_UND1 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Shifts take the iterative path; everything else is single-cycle
  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction
endpackage

// File: rtl/alu_comb.sv
// Single-cycle ops and branch compare. Shift codes yield 0 here; the
// iterative path in iter_alu supplies their result.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             taken,
  output logic             illegal
);
  logic [WIDTH-1:0] diff;
  logic             eq, lt_s, lt_u;

  assign diff = a - b;
  assign eq   = (a == b);
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  // Result/flag select by op code
  always_comb begin
    res     = '0;
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = diff;
      OP_XOR:  res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: res = '0;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_BEQ:  begin res = diff; taken = eq;    end
      OP_BNE:  begin res = diff; taken = !eq;   end
      OP_BLT:  begin res = diff; taken = lt_s;  end
      OP_BGE:  begin res = diff; taken = !lt_s; end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/iter_alu.sv
// EX-stage execution unit: single-cycle logic/arith/compare, one-bit-per-cycle
// shifts, valid/ready on both sides. Result and flags are held until taken.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);
  state_e           state;
  alu_op_e          op_e, sop;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [SHW-1:0]   cnt, shamt;
  logic             accept;
  logic [WIDTH-1:0] c_res;
  logic             c_taken, c_ill;

  assign op_e     = alu_op_e'(op);
  assign shamt    = b[SHW-1:0];
  assign in_ready = (state == IDLE);
  // flush blocks acceptance even though in_ready may be high this cycle
  assign accept   = in_valid && in_ready && !flush;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op      (op_e),
    .a       (a),
    .b       (b),
    .res     (c_res),
    .taken   (c_taken),
    .illegal (c_ill)
  );

  // One-bit step of the shift accumulator in the direction of the latched op
  always_comb begin
    acc_nxt = acc;
    case (sop)
      OP_SLL:  acc_nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[WIDTH-1:1]};
      default: acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      sop          <= OP_SLL;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      out_valid    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (is_shift(op_e) && shamt != '0) begin
            acc   <= a;
            cnt   <= shamt;
            sop   <= op_e;
            state <= SHIFT;
          end else begin
            // shift by zero passes a through; alu_comb covers the rest
            result       <= is_shift(op_e) ? a : c_res;
            zero         <= is_shift(op_e) ? (a == '0) : (c_res == '0);
            branch_taken <= c_taken;
            illegal      <= c_ill;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            result       <= acc_nxt;
            zero         <= (acc_nxt == '0);
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed vector table, random ops against a plain
// arithmetic model, and hand-written handshake/flush/reset sequences.
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, branch_taken, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_alu dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op_i),
    .a            (a_i),
    .b            (b_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        z, bt, ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: results straight from the op definitions
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic z, output logic bt,
                                output logic ill, output int lat);
    int sh;
    sh  = int'(b % 32);
    res = 0; bt = 0; ill = 0; lat = 1;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = a + b;
      4'd3:  res = a - b;
      4'd4:  res = a ^ b;
      4'd5:  res = a << sh;
      4'd6:  res = a >> sh;
      4'd7:  res = $unsigned($signed(a) >>> sh);
      4'd8:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin res = a - b; bt = (a == b); end
      4'd11: begin res = a - b; bt = (a != b); end
      4'd12: begin res = a - b; bt = ($signed(a) <  $signed(b)); end
      4'd13: begin res = a - b; bt = ($signed(a) >= $signed(b)); end
      default: ill = 1;
    endcase
    if (op >= 4'd5 && op <= 4'd7 && sh != 0) lat = sh + 1;
    z = (res == 0);
  endfunction

  // Issue one op with out_ready high; lat counts edges from accept to out_valid
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic bt,
                        output logic ill, output int lat);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result; z = zero; bt = branch_taken; ill = illegal;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, er, ra, rb;
    logic z, bt, il, ez, ebt, eil;
    logic [3:0] rop;
    int lat, elat;
    logic seen;

    vt.push_back('{4'd2,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd3,  32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0, 1});
    vt.push_back('{4'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32});
    vt.push_back('{4'd6,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 1'b0, 32});
    vt.push_back('{4'd5,  32'd1,        32'h25,       32'h20,       1'b0, 1'b0, 1'b0, 6});
    vt.push_back('{4'd5,  32'hABCD,     32'h20,       32'hABCD,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd7,  32'h40000000, 32'd3,        32'h08000000, 1'b0, 1'b0, 1'b0, 4});
    vt.push_back('{4'd12, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1});
    vt.push_back('{4'd13, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, 1});
    vt.push_back('{4'd8,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd10, 32'd7,        32'd7,        32'd0,        1'b1, 1'b1, 1'b0, 1});
    vt.push_back('{4'd11, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 1});
    vt.push_back('{4'd0,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd4,  32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1});
    vt.push_back('{4'd1,  32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1});
    vt.push_back('{4'd14, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1'b1, 1});
    vt.push_back('{4'd15, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b1, 1});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {result, zero, branch_taken, illegal, out_valid, in_ready},
        {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    reset = 1'b0;

    // directed table
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, z, bt, il, lat);
      chk($sformatf("vec%0d_out", i), {r, z, bt, il}, {vt[i].res, vt[i].z, vt[i].bt, vt[i].ill});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
    end

    // random ops vs model
    for (int n = 0; n < 120; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      model(rop, ra, rb, er, ez, ebt, eil, elat);
      run_op(rop, ra, rb, r, z, bt, il, lat);
      chk($sformatf("rnd%0d_op%0d_out", n, rop), {r, z, bt, il}, {er, ez, ebt, eil});
      chk($sformatf("rnd%0d_op%0d_lat", n, rop), 64'(lat), 64'(elat));
    end

    // backpressure: result held, second request ignored while DONE
    @(negedge clk);
    op_i = 4'd2; a_i = 32'd10; b_i = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_first", {out_valid, result}, {1'b1, 32'd30});
    @(negedge clk);
    op_i = 4'd1; a_i = 32'd1; b_i = 32'd2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd30});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});

    // flush in IDLE blocks acceptance
    @(negedge clk);
    op_i = 4'd2; a_i = 32'd1; b_i = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_gate", {in_ready, out_valid}, {1'b1, 1'b0});
    @(posedge clk); #1;
    chk("flush_gate_after", {in_ready, out_valid}, {1'b1, 1'b0});

    // flush on the 3rd cycle of SLL by 10
    @(negedge clk);
    op_i = 4'd5; a_i = 32'd1; b_i = 32'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {in_ready, out_valid}, {1'b1, 1'b0});
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run_op(4'd2, 32'd2, 32'd3, r, z, bt, il, lat);
    chk("flush_next_add", {r, z, 32'(lat)}, {32'd5, 1'b0, 32'd1});

    // async reset mid-shift, between edges
    @(negedge clk);
    op_i = 4'd7; a_i = 32'h80000000; b_i = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_result", {out_valid, result}, {1'b0, 32'd5});
    reset = 1'b1;
    #1;
    chk("async_reset", {result, zero, branch_taken, illegal, out_valid, in_ready},
        {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    #1;
    reset = 1'b0;
    run_op(4'd15, 32'h1234, 32'h5678, r, z, bt, il, lat);
    chk("post_reset_illegal", {r, z, bt, il, 32'(lat)}, {32'd0, 1'b1, 1'b0, 1'b1, 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
